// File: rtl/uart_rx_deserializer.sv
// rtl/uart_rx_deserializer.sv - UART receive deserializer feeding a write-only FIFO port
module uart_rx_deserializer #(
  parameter int CLKS_PER_BIT = 10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       serial_in,
  input  logic       fifo_full,
  input  logic       clear_errors,
  output logic [7:0] w_data,
  output logic       w_enable,
  output logic       framing_error,
  output logic       overrun_error,
  output logic       busy
);

  localparam int TW = $clog2(CLKS_PER_BIT);
  localparam logic [TW-1:0] HALF_M1 = TW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [TW-1:0] FULL_M1 = TW'(CLKS_PER_BIT - 1);
  localparam logic [TW-1:0] ONE     = TW'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_LOAD
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic            sync1;
  logic            sin_s;
  logic            sin_prev;
  logic [TW-1:0]   timer;
  logic [2:0]      bit_cnt;
  logic [7:0]      shreg;
  logic            sample_tick;
  logic            set_fe;
  logic            set_oe;
  logic            load_data;

  // Two-flop synchronizer plus previous-sample register; all preset high so reset never looks like a start edge
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1    <= 1'b1;
      sin_s    <= 1'b1;
      sin_prev <= 1'b1;
    end else begin
      sync1    <= serial_in;
      sin_s    <= sync1;
      sin_prev <= sin_s;
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Next-state, sample strobe and error/write decisions; timer value N-1 marks a bit centre after the half-bit offset
  always_comb begin
    state_nxt   = state;
    sample_tick = 1'b0;
    set_fe      = 1'b0;
    set_oe      = 1'b0;
    load_data   = 1'b0;
    w_enable    = 1'b0;
    case (state)
      S_IDLE: begin
        if (sin_prev && !sin_s) state_nxt = S_START;
      end
      S_START: begin
        if (timer == HALF_M1) begin
          sample_tick = 1'b1;
          state_nxt   = sin_s ? S_IDLE : S_DATA;
        end
      end
      S_DATA: begin
        if (timer == FULL_M1) begin
          sample_tick = 1'b1;
          if (bit_cnt == 3'd7) state_nxt = S_STOP;
        end
      end
      S_STOP: begin
        if (timer == FULL_M1) begin
          sample_tick = 1'b1;
          if (sin_s) begin
            load_data = 1'b1;
            state_nxt = S_LOAD;
          end else begin
            set_fe    = 1'b1;
            state_nxt = S_IDLE;
          end
        end
      end
      S_LOAD: begin
        w_enable  = !fifo_full;
        set_oe    = fifo_full;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Bit timer: held at zero while idle, restarted at every sample point so it never wraps
  always_ff @(posedge clk) begin
    if (rst || state == S_IDLE || state == S_LOAD || sample_tick) timer <= '0;
    else                                                         timer <= timer + ONE;
  end

  // Data bit counter, advanced on each data-bit sample
  always_ff @(posedge clk) begin
    if (rst || state == S_IDLE)            bit_cnt <= 3'd0;
    else if (state == S_DATA && sample_tick) bit_cnt <= bit_cnt + 3'd1;
  end

  // LSB-first shift register: new bit enters at the MSB
  always_ff @(posedge clk) begin
    if (rst)                                 shreg <= 8'h00;
    else if (state == S_DATA && sample_tick) shreg <= {sin_s, shreg[7:1]};
  end

  // Output byte captured only when entering LOAD
  always_ff @(posedge clk) begin
    if (rst)            w_data <= 8'h00;
    else if (load_data) w_data <= shreg;
  end

  // Sticky error flags; a new error wins over a simultaneous clear
  always_ff @(posedge clk) begin
    if (rst) begin
      framing_error <= 1'b0;
      overrun_error <= 1'b0;
    end else begin
      framing_error <= set_fe | (framing_error & ~clear_errors);
      overrun_error <= set_oe | (overrun_error & ~clear_errors);
    end
  end

  assign busy = (state != S_IDLE);

endmodule
